// File: rtl/dht11_multi_ctrl.sv
// Multi-channel DHT11 reader: one protocol engine scans N_CH open-drain lines round-robin.
// Optional macro DHT_DECIMAL_EN adds rh_dec/t_dec ports carrying the fractional bytes.
module dht11_multi_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int N_CH          = 2,
    parameter int POLL_MS       = 2000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 40,
    parameter int MAX_RETRY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_en,
    inout  wire  [N_CH-1:0]   dht_io,
    output logic [8*N_CH-1:0] rh_data,
    output logic [8*N_CH-1:0] t_data,
`ifdef DHT_DECIMAL_EN
    output logic [8*N_CH-1:0] rh_dec,
    output logic [8*N_CH-1:0] t_dec,
`endif
    output logic [N_CH-1:0]   valid,
    output logic [N_CH-1:0]   err,
    output logic              busy,
    output logic              done,
    output logic [3:0]        state
);

    // state    | meaning
    // IDLE   0 | waiting for start or poll expiry
    // START  1 | host drives selected line low
    // REL    2 | line released, sensor turnaround
    // RSP_L  3 | waiting for sensor response low
    // RSP_H  4 | waiting for sensor response high
    // BIT_L  5 | waiting for rising edge that starts a data bit
    // BIT_H  6 | timing data-high width, bit shifted on the fall
    // CHECK  7 | checksum compare, result latched
    // NEXT   8 | inter-channel guard, advance or finish sweep
    // FAIL   9 | retry after guard, or flag error
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_START = 4'd1;
    localparam logic [3:0] S_REL   = 4'd2;
    localparam logic [3:0] S_RSP_L = 4'd3;
    localparam logic [3:0] S_RSP_H = 4'd4;
    localparam logic [3:0] S_BIT_L = 4'd5;
    localparam logic [3:0] S_BIT_H = 4'd6;
    localparam logic [3:0] S_CHECK = 4'd7;
    localparam logic [3:0] S_NEXT  = 4'd8;
    localparam logic [3:0] S_FAIL  = 4'd9;

    localparam int TICK_DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
    localparam int DIV_W    = $clog2(TICK_DIV + 1);
    localparam int REL_US   = 30;
    localparam int GUARD_US = 1000;
    localparam int TMR_W    = $clog2(START_LOW_US + GUARD_US + TIMEOUT_US + 1);
    localparam int POLL_US  = POLL_MS * 1000;
    localparam int POLL_W   = $clog2(POLL_US + 1);
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int HI_LIM   = TIMEOUT_US - BIT_THRESH_US;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick_us;
    logic [N_CH-1:0]   sync1, sync2;
    logic              line, line_q;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_due, trigger;
    logic [TMR_W-1:0]  tmr;
    logic              tc;
    logic [CH_W-1:0]   ch;
    logic [RTY_W-1:0]  retry_cnt;
    logic [39:0]       shreg;
    logic [5:0]        bit_cnt;
    logic [7:0]        sum8;
    logic              sum_ok, bit_one;
    logic [7:0]        rh_r [N_CH];
    logic [7:0]        t_r  [N_CH];
`ifdef DHT_DECIMAL_EN
    logic [7:0]        rhd_r [N_CH];
    logic [7:0]        td_r  [N_CH];
`endif

    assign tick_us = (div_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick_us) begin
            div_cnt <= DIV_W'(TICK_DIV - 1);
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    // Idle lines float high, so the synchroniser resets to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= dht_io;
            sync2 <= sync1;
        end
    end

    assign line     = sync2[ch];
    assign poll_due = auto_en && (poll_cnt == '0);
    assign trigger  = (state == S_IDLE) && !done && (start || poll_due);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt <= '0;
        end else if (trigger) begin
            poll_cnt <= POLL_W'(POLL_US - 1);
        end else if (auto_en && tick_us && poll_cnt != '0) begin
            poll_cnt <= poll_cnt - 1'b1;
        end
    end

    assign tc      = (tmr == '0);
    assign sum8    = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
    assign sum_ok  = (sum8 == shreg[7:0]);
    // The phase timer counts down from TIMEOUT_US, so high width = TIMEOUT_US - tmr.
    assign bit_one = (tmr < TMR_W'(HI_LIM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ch        <= '0;
            retry_cnt <= '0;
            tmr       <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            line_q    <= 1'b1;
            valid     <= '0;
            err       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rh_r[i] <= '0;
                t_r[i]  <= '0;
`ifdef DHT_DECIMAL_EN
                rhd_r[i] <= '0;
                td_r[i]  <= '0;
`endif
            end
        end else begin
            done   <= 1'b0;
            line_q <= line;
            if (tick_us && !tc) begin
                tmr <= tmr - 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state     <= S_START;
                        ch        <= '0;
                        retry_cnt <= '0;
                        tmr       <= TMR_W'(START_LOW_US);
                    end
                end
                S_START: begin
                    if (tc) begin
                        state <= S_REL;
                        tmr   <= TMR_W'(REL_US);
                    end
                end
                S_REL: begin
                    if (tc) begin
                        state <= S_RSP_L;
                        tmr   <= TMR_W'(TIMEOUT_US);
                    end
                end
                S_RSP_L: begin
                    if (!line) begin
                        state <= S_RSP_H;
                        tmr   <= TMR_W'(TIMEOUT_US);
                    end else if (tc) begin
                        state <= S_FAIL;
                        tmr   <= TMR_W'(GUARD_US);
                    end
                end
                S_RSP_H: begin
                    if (line) begin
                        state   <= S_BIT_L;
                        bit_cnt <= '0;
                        tmr     <= TMR_W'(TIMEOUT_US);
                    end else if (tc) begin
                        state <= S_FAIL;
                        tmr   <= TMR_W'(GUARD_US);
                    end
                end
                S_BIT_L: begin
                    if (line && !line_q) begin
                        state <= S_BIT_H;
                        tmr   <= TMR_W'(TIMEOUT_US);
                    end else if (tc) begin
                        state <= S_FAIL;
                        tmr   <= TMR_W'(GUARD_US);
                    end
                end
                S_BIT_H: begin
                    if (!line) begin
                        shreg   <= {shreg[38:0], bit_one};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 6'd39) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_BIT_L;
                            tmr   <= TMR_W'(TIMEOUT_US);
                        end
                    end else if (tc) begin
                        state <= S_FAIL;
                        tmr   <= TMR_W'(GUARD_US);
                    end
                end
                S_CHECK: begin
                    tmr <= TMR_W'(GUARD_US);
                    if (sum_ok) begin
                        rh_r[ch]  <= shreg[39:32];
                        t_r[ch]   <= shreg[23:16];
`ifdef DHT_DECIMAL_EN
                        rhd_r[ch] <= shreg[31:24];
                        td_r[ch]  <= shreg[15:8];
`endif
                        valid[ch] <= 1'b1;
                        err[ch]   <= 1'b0;
                        state     <= S_NEXT;
                    end else begin
                        state <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        if (tc) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_START;
                            tmr       <= TMR_W'(START_LOW_US);
                        end
                    end else begin
                        valid[ch] <= 1'b0;
                        err[ch]   <= 1'b1;
                        state     <= S_NEXT;
                        tmr       <= TMR_W'(GUARD_US);
                    end
                end
                S_NEXT: begin
                    if (tc) begin
                        retry_cnt <= '0;
                        if (ch == CH_W'(N_CH - 1)) begin
                            ch    <= '0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= S_START;
                            tmr   <= TMR_W'(START_LOW_US);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE) || done;

    // Drive is decoded straight from registers so reset releases the line asynchronously.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign dht_io[i]         = (state == S_START && ch == CH_W'(i)) ? 1'b0 : 1'bz;
        assign rh_data[8*i +: 8] = rh_r[i];
        assign t_data[8*i +: 8]  = t_r[i];
`ifdef DHT_DECIMAL_EN
        assign rh_dec[8*i +: 8]  = rhd_r[i];
        assign t_dec[8*i +: 8]   = td_r[i];
`endif
    end

endmodule

// File: tb/tb_dht11_multi_ctrl.sv
// Bench for dht11_multi_ctrl: two behavioural DHT11 sensors, vector table plus scoreboard.
`timescale 1ns/1ps
module tb_dht11_multi_ctrl;

    localparam int US      = 1000;
    localparam int POLL_US = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    wire  [1:0]  dht_io;
    logic [15:0] rh_data, t_data;
    logic [1:0]  valid, err;
    logic        busy, done;
    logic [3:0]  state;
`ifdef DHT_DECIMAL_EN
    logic [15:0] rh_dec, t_dec;
`endif

    dht11_multi_ctrl #(
        .CLK_HZ(1_000_000), .N_CH(2), .POLL_MS(1), .START_LOW_US(100),
        .TIMEOUT_US(200), .BIT_THRESH_US(40), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .dht_io(dht_io),
        .rh_data(rh_data), .t_data(t_data),
`ifdef DHT_DECIMAL_EN
        .rh_dec(rh_dec), .t_dec(t_dec),
`endif
        .valid(valid), .err(err), .busy(busy), .done(done), .state(state)
    );

    always #(US/2) clk = ~clk;

    pullup (dht_io[0]);
    pullup (dht_io[1]);

    logic [39:0] frame [2];
    int          sil_until [2];

    // Each sensor answers a host low >= 80 us once its start count passes sil_until.
    for (genvar g = 0; g < 2; g++) begin : g_sens
        logic low = 1'b0;
        int   starts = 0;
        assign dht_io[g] = low ? 1'b0 : 1'bz;
        initial begin
            realtime t0;
            logic [39:0] f;
            forever begin
                @(negedge dht_io[g]);
                t0 = $realtime;
                @(posedge dht_io[g]);
                if ($realtime - t0 >= 80.0 * US) begin
                    starts++;
                    if (starts > sil_until[g]) begin
                        f = frame[g];
                        #(25*US) low = 1'b1;
                        #(20*US) low = 1'b0;
                        #(20*US);
                        for (int b = 39; b >= 0; b--) begin
                            low = 1'b1;
                            #(12*US) low = 1'b0;
                            if (f[b]) #(50*US); else #(10*US);
                        end
                        low = 1'b1;
                        #(12*US) low = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [15:0] rh, t, rdec, tdec;
        logic [1:0]  v, e;
    } exp_t;

    typedef struct {
        logic [39:0] f0, f1;
        int          s0, s1;
        logic [15:0] rh, t;
        logic [1:0]  v, e;
        logic [15:0] rdec, tdec;
        int          st0, st1;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[5];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got done pulse, want none at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("done_busy", busy, 1);
                chk("rh_data", rh_data, mon_e.rh);
                chk("t_data", t_data, mon_e.t);
                chk("valid", valid, mon_e.v);
                chk("err", err, mon_e.e);
`ifdef DHT_DECIMAL_EN
                chk("rh_dec", rh_dec, mon_e.rdec);
                chk("t_dec", t_dec, mon_e.tdec);
`endif
            end
        end
    end

    task automatic run_vec(input int i);
        exp_t e;
        int   b0, b1, d0;
        frame[0] = vt[i].f0;
        frame[1] = vt[i].f1;
        b0 = g_sens[0].starts;
        b1 = g_sens[1].starts;
        sil_until[0] = b0 + vt[i].s0;
        sil_until[1] = b1 + vt[i].s1;
        e = '{rh: vt[i].rh, t: vt[i].t, rdec: vt[i].rdec, tdec: vt[i].tdec, v: vt[i].v, e: vt[i].e};
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        sb.push_back(e);
        @(negedge clk) start = 1'b0;
        wait_done(d0, 40000, $sformatf("vec%0d_done", i));
        repeat (2) @(negedge clk);
        chk($sformatf("vec%0d_starts_ch0", i), g_sens[0].starts - b0, vt[i].st0);
        chk($sformatf("vec%0d_starts_ch1", i), g_sens[1].starts - b1, vt[i].st1);
    endtask

    initial begin
        #(150_000 * US);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1;
        int   d0, n;

        vt[0] = '{{8'd45,8'd0,8'd23,8'd0,8'd68}, {8'd60,8'd0,8'd30,8'd0,8'd90}, 0, 0,
                  16'h3C2D, 16'h1E17, 2'b11, 2'b00, 16'h0000, 16'h0000, 1, 1};
        vt[1] = '{{8'd45,8'd0,8'd23,8'd0,8'd68}, {8'd61,8'd0,8'd31,8'd0,8'd0}, 0, 0,
                  16'h3C2D, 16'h1E17, 2'b01, 2'b10, 16'h0000, 16'h0000, 1, 3};
        vt[2] = '{{8'd50,8'd0,8'd20,8'd0,8'd70}, {8'd70,8'd0,8'd25,8'd0,8'd95}, 1, 0,
                  16'h4632, 16'h1914, 2'b11, 2'b00, 16'h0000, 16'h0000, 2, 1};
        vt[3] = '{{8'd45,8'd3,8'd23,8'd7,8'd78}, {8'd255,8'd255,8'd255,8'd255,8'd252}, 0, 0,
                  16'hFF2D, 16'hFF17, 2'b11, 2'b00, 16'hFF03, 16'hFF07, 1, 1};
        vt[4] = '{{8'd200,8'd10,8'd50,8'd5,8'd9}, {8'd60,8'd0,8'd30,8'd0,8'd90}, 0, 3,
                  16'hFFC8, 16'hFF32, 2'b01, 2'b10, 16'hFF0A, 16'hFF05, 1, 3};
        e1 = '{rh: 16'h3C2D, t: 16'h1E17, rdec: 16'h0, tdec: 16'h0, v: 2'b11, e: 2'b00};
        frame[0] = '0;
        frame[1] = '0;
        sil_until[0] = 0;
        sil_until[1] = 0;

        repeat (5) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_rh", rh_data, 0);
        chk("rst_t", t_data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", dht_io, 2'b11);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Auto-poll: first sweep one poll period after enable, then back-to-back.
        frame[0] = vt[0].f0;
        frame[1] = vt[0].f1;
        sil_until[0] = g_sens[0].starts;
        sil_until[1] = g_sens[1].starts;
        sb.push_back(e1);
        sb.push_back(e1);
        d0 = done_cnt;
        auto_en = 1'b1;
        n = 0;
        while (!busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n < POLL_US - 2 || n > POLL_US + 2) begin
            n_bad++;
            $display("FAIL poll_delay: got %0d cycles, want %0d +/-2", n, POLL_US);
        end
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(d0, 20000, "auto_sweep1");
        repeat (4) @(negedge clk);
        chk("auto_second_state", state, 4'd1);
        chk("auto_second_busy", busy, 1);
        repeat (50) @(negedge clk);
        auto_en = 1'b0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(d0 + 1, 20000, "auto_sweep2");
        repeat (POLL_US + 500) @(negedge clk);
        chk("auto_done_count", done_cnt - d0, 2);
        chk("auto_off_idle", busy, 0);
        chk("sb_drained", sb.size(), 0);

        // Reset while driving the start pulse, then while timing a data bit.
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        chk("start_drive_low", dht_io[0], 0);
        #(US/4) rst = 1'b0;
        #1;
        chk("rst_start_release", dht_io[0], 1);
        chk("rst_start_state", state, 0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (state != 4'd6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit_h", state, 4'd6);
        #1 rst = 1'b0;
        #1;
        chk("rst_bit_lines", dht_io, 2'b11);
        chk("rst_bit_state", state, 0);
        chk("rst_bit_rh", rh_data, 0);
        chk("rst_bit_t", t_data, 0);
        chk("rst_bit_valid", valid, 0);
        chk("rst_bit_err", err, 0);
        chk("rst_bit_busy", busy, 0);
        chk("rst_bit_done", done, 0);
`ifdef DHT_DECIMAL_EN
        chk("rst_bit_rh_dec", rh_dec, 0);
        chk("rst_bit_t_dec", t_dec, 0);
`endif
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3000) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_stays_idle", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
